// File: rtl/game_sequencer.sv
// Shares the 7-segment display and four game buttons among NUM_GAMES games: splash, play, idle blank.
// Optional idle blanking is enabled by defining GAME_SEQ_IDLE_BLANK_EN.
module game_sequencer #(
    parameter int unsigned      NUM_GAMES     = 3,
    parameter int unsigned      CNT_W         = 24,
    parameter logic [CNT_W-1:0] SPLASH_CYCLES = CNT_W'(6_000_000),
    parameter logic [CNT_W-1:0] IDLE_CYCLES   = CNT_W'(15_000_000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        switch_pulse,
    input  logic [3:0]  btn_pulse,
    input  logic [15:0] game_value,
    output logic [1:0]  game_sel,
    output logic [15:0] game_btn,
    output logic [3:0]  disp_value,
    output logic        splash_active,
    output logic        idle_active
);

    typedef enum logic [1:0] {
        SPLASH = 2'd0,
        PLAY   = 2'd1,
        IDLE   = 2'd2
    } state_t;

    localparam logic [1:0]       LAST_GAME   = 2'(NUM_GAMES - 1);
    localparam logic [CNT_W-1:0] SPLASH_LAST = SPLASH_CYCLES - CNT_W'(1);
    localparam logic [3:0]       BLANK       = 4'd12;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_next_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign sel_next_c = (game_sel == LAST_GAME) ? 2'd0 : game_sel + 2'd1;
    // Saturating increment so a long dwell can never wrap the counter
    assign cnt_inc_c  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef GAME_SEQ_IDLE_BLANK_EN
    localparam logic [CNT_W-1:0] IDLE_LAST = IDLE_CYCLES - CNT_W'(1);
    logic btn_any_c;
    assign btn_any_c = |btn_pulse;
`else
    // Idle timeout does not exist in this build
    logic unused_idle_cycles;
    assign unused_idle_cycles = ^IDLE_CYCLES;
`endif

    // State, game selection and shared splash/idle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SPLASH;
            game_sel <= 2'd0;
            cnt      <= '0;
        end else if (switch_pulse) begin
            state    <= SPLASH;
            game_sel <= sel_next_c;
            cnt      <= '0;
        end else begin
            case (state)
                SPLASH: begin
                    if (cnt == SPLASH_LAST) begin
                        state <= PLAY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end
                PLAY: begin
`ifdef GAME_SEQ_IDLE_BLANK_EN
                    if (btn_any_c) begin
                        cnt <= '0;
                    end else if (cnt == IDLE_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
`else
                    cnt <= '0;
`endif
                end
`ifdef GAME_SEQ_IDLE_BLANK_EN
                IDLE: begin
                    if (btn_any_c) begin
                        state <= PLAY;
                        cnt   <= '0;
                    end
                end
`endif
                default: begin
                    state <= SPLASH;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Display and button routing decoded from registered state and live inputs
    always_comb begin
        disp_value    = 4'd0;
        game_btn      = '0;
        splash_active = 1'b0;
        idle_active   = 1'b0;
        case (state)
            SPLASH: begin
                disp_value    = {2'b00, game_sel} + 4'd1;
                splash_active = 1'b1;
            end
            PLAY: begin
                disp_value = game_value[{game_sel, 2'b00} +: 4];
                if (!switch_pulse) begin
                    game_btn[{game_sel, 2'b00} +: 4] = btn_pulse;
                end
            end
`ifdef GAME_SEQ_IDLE_BLANK_EN
            IDLE: begin
                disp_value  = BLANK;
                idle_active = 1'b1;
            end
`endif
            default: begin
                disp_value = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus randomized run against a counting model.
module tb_game_sequencer;

    localparam int NG       = 3;
    localparam int N_SPLASH = 4;
    localparam int N_IDLE   = 8;
`ifdef GAME_SEQ_IDLE_BLANK_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif
    localparam int PH_SPLASH = 0;
    localparam int PH_PLAY   = 1;
    localparam int PH_IDLE   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        switch_pulse = 1'b0;
    logic [3:0]  btn_pulse = 4'd0;
    logic [15:0] game_value = 16'h0753;
    logic [1:0]  game_sel;
    logic [15:0] game_btn;
    logic [3:0]  disp_value;
    logic        splash_active;
    logic        idle_active;

    int cmp_n = 0;
    int fail_n = 0;

    // Reference model: phase plus elapsed-cycle counts
    int m_phase, m_sel, m_seen, m_quiet;
    logic [3:0]  exp_disp;
    logic [15:0] exp_btn;
    logic        exp_splash, exp_idle;
    logic [1:0]  exp_sel;

    game_sequencer #(
        .NUM_GAMES(NG), .CNT_W(24), .SPLASH_CYCLES(24'd4), .IDLE_CYCLES(24'd8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
        .game_value(game_value), .game_sel(game_sel), .game_btn(game_btn),
        .disp_value(disp_value), .splash_active(splash_active), .idle_active(idle_active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = PH_SPLASH; m_sel = 0; m_seen = 0; m_quiet = 0;
    endtask

    task automatic model_outputs();
        exp_sel = 2'(m_sel); exp_btn = '0; exp_splash = 1'b0; exp_idle = 1'b0;
        if (m_phase == PH_SPLASH) begin
            exp_disp = 4'(m_sel + 1); exp_splash = 1'b1;
        end else if (m_phase == PH_PLAY) begin
            exp_disp = 4'(game_value >> (4 * m_sel));
            if (!switch_pulse) exp_btn = 16'(btn_pulse) << (4 * m_sel);
        end else begin
            exp_disp = 4'd12; exp_idle = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (switch_pulse) begin
            m_sel = (m_sel + 1) % NG; m_phase = PH_SPLASH; m_seen = 0;
        end else if (m_phase == PH_SPLASH) begin
            m_seen++;
            if (m_seen == N_SPLASH) begin m_phase = PH_PLAY; m_quiet = 0; end
        end else if (m_phase == PH_PLAY) begin
            if (IDLE_EN) begin
                if (btn_pulse != 4'd0) m_quiet = 0; else m_quiet++;
                if (m_quiet == N_IDLE) m_phase = PH_IDLE;
            end
        end else if (btn_pulse != 4'd0) begin
            m_phase = PH_PLAY; m_quiet = 0;
        end
    endtask

    // Drive inputs just after a rising edge, then settle mid-cycle
    task automatic set_in(input logic sw, input logic [3:0] btn);
        switch_pulse = sw; btn_pulse = btn;
        #2;
        model_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
        switch_pulse = 1'b0; btn_pulse = 4'd0;
    endtask

    // Reset, release on a cycle boundary, and run the first splash into PLAY
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N_SPLASH; i++) begin set_in(1'b0, 4'd0); advance(); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_pulse = 4'b1111; #3;
        cmp_n++; if (game_sel !== 2'd0) begin fail_n++; $display("FAIL reset_sel: got %0d want 0", game_sel); end
        cmp_n++; if (disp_value !== 4'd1) begin fail_n++; $display("FAIL reset_disp: got %0d want 1", disp_value); end
        cmp_n++; if (splash_active !== 1'b1 || idle_active !== 1'b0) begin fail_n++; $display("FAIL reset_flags: got splash=%b idle=%b want 1 0", splash_active, idle_active); end
        cmp_n++; if (game_btn !== 16'h0) begin fail_n++; $display("FAIL reset_btn: got %h want 0000", game_btn); end
        btn_pulse = 4'd0;
        @(posedge clk); #1; rst_n = 1'b1; model_reset();
        for (int i = 0; i < N_SPLASH; i++) begin
            set_in(1'b0, 4'd0);
            cmp_n++; if (splash_active !== 1'b1 || disp_value !== 4'd1) begin fail_n++; $display("FAIL splash_hold[%0d]: got splash=%b disp=%0d want 1 1", i, splash_active, disp_value); end
            advance();
        end
        set_in(1'b0, 4'd0);
        cmp_n++; if (splash_active !== 1'b0 || disp_value !== 4'd3 || game_sel !== 2'd0) begin fail_n++; $display("FAIL splash_end: got splash=%b disp=%0d sel=%0d want 0 3 0", splash_active, disp_value, game_sel); end
    endtask

    task automatic test_btn_routing();
        do_reset();
        set_in(1'b0, 4'b0010);
        cmp_n++; if (game_btn !== 16'h0002) begin fail_n++; $display("FAIL play_btn_g0: got %h want 0002", game_btn); end
        advance();
        set_in(1'b1, 4'd0); advance();
        set_in(1'b0, 4'b0010);
        cmp_n++; if (game_btn !== 16'h0000 || splash_active !== 1'b1) begin fail_n++; $display("FAIL splash_btn_drop: got btn=%h splash=%b want 0000 1", game_btn, splash_active); end
        advance();
        for (int i = 1; i < N_SPLASH; i++) begin set_in(1'b0, 4'd0); advance(); end
        set_in(1'b0, 4'b1000);
        cmp_n++; if (game_btn !== 16'h0080 || disp_value !== 4'd5) begin fail_n++; $display("FAIL play_btn_g1: got btn=%h disp=%0d want 0080 5", game_btn, disp_value); end
        advance();
    endtask

    task automatic test_switch_sequence();
        logic [1:0] want_sel [3];
        logic [3:0] want_splash [3];
        logic [3:0] want_play [3];
        want_sel = '{2'd1, 2'd2, 2'd0};
        want_splash = '{4'd2, 4'd3, 4'd1};
        want_play = '{4'd5, 4'd7, 4'd3};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            set_in(1'b1, 4'd0); advance();
            for (int i = 0; i < N_SPLASH; i++) begin
                set_in(1'b0, 4'd0);
                cmp_n++; if (splash_active !== 1'b1 || disp_value !== want_splash[s] || game_sel !== want_sel[s]) begin fail_n++; $display("FAIL switch_splash[%0d.%0d]: got splash=%b disp=%0d sel=%0d want 1 %0d %0d", s, i, splash_active, disp_value, game_sel, want_splash[s], want_sel[s]); end
                advance();
            end
            set_in(1'b0, 4'd0);
            cmp_n++; if (splash_active !== 1'b0 || disp_value !== want_play[s]) begin fail_n++; $display("FAIL switch_play[%0d]: got splash=%b disp=%0d want 0 %0d", s, splash_active, disp_value, want_play[s]); end
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < N_IDLE; i++) begin
            set_in(1'b0, 4'd0);
            cmp_n++; if (disp_value !== 4'd3 || idle_active !== 1'b0) begin fail_n++; $display("FAIL idle_quiet[%0d]: got disp=%0d idle=%b want 3 0", i, disp_value, idle_active); end
            advance();
        end
        if (IDLE_EN) begin
            set_in(1'b0, 4'b0001);
            cmp_n++; if (disp_value !== 4'd12 || idle_active !== 1'b1) begin fail_n++; $display("FAIL idle_blank: got disp=%0d idle=%b want 12 1", disp_value, idle_active); end
            cmp_n++; if (game_btn !== 16'h0) begin fail_n++; $display("FAIL idle_wake_btn: got %h want 0000", game_btn); end
            advance();
            set_in(1'b0, 4'd0);
            cmp_n++; if (disp_value !== 4'd3 || idle_active !== 1'b0 || game_sel !== 2'd0) begin fail_n++; $display("FAIL idle_wake: got disp=%0d idle=%b sel=%0d want 3 0 0", disp_value, idle_active, game_sel); end
            advance();
        end else begin
            for (int i = 0; i < 3 * N_IDLE; i++) begin
                set_in(1'b0, 4'd0);
                cmp_n++; if (disp_value !== 4'd3 || idle_active !== 1'b0) begin fail_n++; $display("FAIL no_blank[%0d]: got disp=%0d idle=%b want 3 0", i, disp_value, idle_active); end
                advance();
            end
        end
    endtask

    task automatic test_switch_btn_same();
        do_reset();
        set_in(1'b1, 4'b0001);
        cmp_n++; if (game_btn !== 16'h0) begin fail_n++; $display("FAIL sw_btn_gate: got %h want 0000", game_btn); end
        advance();
        set_in(1'b0, 4'd0);
        cmp_n++; if (game_sel !== 2'd1 || splash_active !== 1'b1) begin fail_n++; $display("FAIL sw_btn_after: got sel=%0d splash=%b want 1 1", game_sel, splash_active); end
    endtask

    task automatic test_reset_mid_splash();
        do_reset();
        set_in(1'b1, 4'd0); advance();
        set_in(1'b1, 4'd0); advance();
        set_in(1'b0, 4'd0); advance();
        set_in(1'b0, 4'd0);
        cmp_n++; if (game_sel !== 2'd2 || disp_value !== 4'd3) begin fail_n++; $display("FAIL pre_reset: got sel=%0d disp=%0d want 2 3", game_sel, disp_value); end
        advance();
        rst_n = 1'b0; #1;
        cmp_n++; if (game_sel !== 2'd0 || disp_value !== 4'd1 || splash_active !== 1'b1) begin fail_n++; $display("FAIL async_reset: got sel=%0d disp=%0d splash=%b want 0 1 1", game_sel, disp_value, splash_active); end
        @(posedge clk); #1; rst_n = 1'b1; model_reset();
        for (int i = 0; i < N_SPLASH; i++) begin
            set_in(1'b0, 4'd0);
            cmp_n++; if (splash_active !== 1'b1 || disp_value !== 4'd1) begin fail_n++; $display("FAIL resplash[%0d]: got splash=%b disp=%0d want 1 1", i, splash_active, disp_value); end
            advance();
        end
        set_in(1'b0, 4'd0);
        cmp_n++; if (splash_active !== 1'b0 || disp_value !== 4'd3) begin fail_n++; $display("FAIL resplash_end: got splash=%b disp=%0d want 0 3", splash_active, disp_value); end
    endtask

    task automatic test_random();
        logic sw;
        logic [3:0] btn;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            sw = ($urandom_range(0, 15) == 0);
            btn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            game_value = 16'($urandom);
            set_in(sw, btn);
            cmp_n++;
            if (disp_value !== exp_disp || game_btn !== exp_btn || splash_active !== exp_splash ||
                idle_active !== exp_idle || game_sel !== exp_sel) begin
                fail_n++;
                $display("FAIL random[%0d]: got disp=%0d btn=%h spl=%b idl=%b sel=%0d want %0d %h %b %b %0d",
                         i, disp_value, game_btn, splash_active, idle_active, game_sel,
                         exp_disp, exp_btn, exp_splash, exp_idle, exp_sel);
            end
            advance();
        end
        game_value = 16'h0753;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_btn_routing();
        test_switch_sequence();
        test_idle();
        test_switch_btn_same();
        test_reset_mid_splash();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
